// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction/state encodings for the snake game control slice
package snake_pkg;

   localparam logic [1:0] DIR_RIGHT = 2'b00;
   localparam logic [1:0] DIR_LEFT  = 2'b01;
   localparam logic [1:0] DIR_UP    = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;

   localparam logic [1:0] GS_IDLE  = 2'b00;
   localparam logic [1:0] GS_RUN   = 2'b01;
   localparam logic [1:0] GS_PAUSE = 2'b10;
   localparam logic [1:0] GS_OVER  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = GS_IDLE,
      ST_RUN   = GS_RUN,
      ST_PAUSE = GS_PAUSE,
      ST_OVER  = GS_OVER
   } game_state_t;

   function automatic logic [1:0] opposite(input logic [1:0] d);
      return d ^ 2'b01;
   endfunction

endpackage

// File: rtl/snake_turn_queue.sv
// rtl/snake_turn_queue.sv - per-player key priority, turn rejection, turn FIFO and dir register
// Optional GCTRL_REVERSE_REJECT_EN also rejects 180-degree reversals.
module snake_turn_queue
   import snake_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clr,
   input  logic       i_push_en,
   input  logic       i_pop_en,
   input  logic       i_up,
   input  logic       i_down,
   input  logic       i_left,
   input  logic       i_right,
   output logic [1:0] o_dir,
   output logic       o_full
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH) + 1;
   localparam logic [PW-1:0] P_LAST = PW'(QDEPTH - 1);
   localparam logic [CW-1:0] C_FULL = CW'(QDEPTH);

   logic [1:0]    r_mem [QDEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [1:0]    r_dir;
   logic          r_full;

   logic          w_cand_vld;
   logic [1:0]    w_cand;
   logic [PW-1:0] w_tail_ptr;
   logic [1:0]    w_ref;
   logic          w_reject;
   logic          w_push;
   logic          w_pop;
   logic          w_ovr;
   logic [PW-1:0] w_wr_addr;
   logic [CW-1:0] w_count_nxt;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == P_LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      w_cand_vld = i_up | i_down | i_left | i_right;
      if (i_up)        w_cand = DIR_UP;
      else if (i_down) w_cand = DIR_DOWN;
      else if (i_left) w_cand = DIR_LEFT;
      else             w_cand = DIR_RIGHT;

      // Compare against the last queued turn so bursts are judged in order
      w_tail_ptr = (r_wr_ptr == '0) ? P_LAST : r_wr_ptr - 1'b1;
      w_ref      = (r_count != '0) ? r_mem[w_tail_ptr] : r_dir;
`ifdef GCTRL_REVERSE_REJECT_EN
      w_reject   = (w_cand == w_ref) || (w_cand == opposite(w_ref));
`else
      w_reject   = (w_cand == w_ref);
`endif
      w_pop  = i_pop_en && (r_count != '0);
      w_push = i_push_en && w_cand_vld && !w_reject;
      // A simultaneous pop frees a slot, so a full queue only overwrites when not popping
      w_ovr     = w_push && (r_count == C_FULL) && !w_pop;
      w_wr_addr = w_ovr ? w_tail_ptr : r_wr_ptr;

      w_count_nxt = r_count;
      if (w_push && !w_ovr) w_count_nxt = w_count_nxt + 1'b1;
      if (w_pop)            w_count_nxt = w_count_nxt - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_dir    <= DIR_RIGHT;
         r_full   <= 1'b0;
         for (int i = 0; i < QDEPTH; i++) r_mem[i] <= DIR_RIGHT;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_dir    <= DIR_RIGHT;
         r_full   <= 1'b0;
      end else begin
         if (w_push)           r_mem[w_wr_addr] <= w_cand;
         if (w_push && !w_ovr) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_dir    <= r_mem[r_rd_ptr];
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == C_FULL);
      end
   end

   assign o_dir  = r_dir;
   assign o_full = r_full;

endmodule

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - game FSM, loser latch and per-player turn queues
// Optional GCTRL_REVERSE_REJECT_EN is applied inside snake_turn_queue.
module snake_game_ctrl
   import snake_pkg::*;
#(
   parameter int NUM_PLAYERS = 1,
   parameter int QDEPTH      = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_PLAYERS-1:0]   up_pulse,
   input  logic [NUM_PLAYERS-1:0]   down_pulse,
   input  logic [NUM_PLAYERS-1:0]   left_pulse,
   input  logic [NUM_PLAYERS-1:0]   right_pulse,
   input  logic                     enter_pulse,
   input  logic                     pause_pulse,
   input  logic                     tick,
   input  logic [NUM_PLAYERS-1:0]   collision,
   output logic [2*NUM_PLAYERS-1:0] dir,
   output logic                     run_en,
   output logic [1:0]               game_state,
   output logic [NUM_PLAYERS-1:0]   loser,
   output logic [NUM_PLAYERS-1:0]   q_full
);

   game_state_t            r_state;
   game_state_t            w_state_nxt;
   logic [NUM_PLAYERS-1:0] r_loser;
   logic                   w_clr;
   logic                   w_latch;
   logic                   w_push_en;
   logic                   w_pop_en;

   always_comb begin
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         ST_IDLE:  if (enter_pulse) w_state_nxt = ST_RUN;
         ST_RUN: begin
            // Death outranks a pause arriving in the same cycle
            if (|collision) begin
               w_state_nxt = ST_OVER;
               w_latch     = 1'b1;
            end else if (pause_pulse) begin
               w_state_nxt = ST_PAUSE;
            end
         end
         ST_PAUSE: if (pause_pulse || enter_pulse) w_state_nxt = ST_RUN;
         ST_OVER: begin
            if (enter_pulse) begin
               w_state_nxt = ST_IDLE;
               w_clr       = 1'b1;
            end
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_loser <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch)    r_loser <= collision;
         else if (w_clr) r_loser <= '0;
      end
   end

   assign w_push_en  = (r_state == ST_RUN) || (r_state == ST_PAUSE);
   assign w_pop_en   = (r_state == ST_RUN) && tick;
   assign run_en     = (r_state == ST_RUN);
   assign game_state = r_state;
   assign loser      = r_loser;

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      snake_turn_queue #(.QDEPTH(QDEPTH)) u_turn_queue (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_clr     (w_clr),
         .i_push_en (w_push_en),
         .i_pop_en  (w_pop_en),
         .i_up      (up_pulse[p]),
         .i_down    (down_pulse[p]),
         .i_left    (left_pulse[p]),
         .i_right   (right_pulse[p]),
         .o_dir     (dir[2*p +: 2]),
         .o_full    (q_full[p])
      );
   end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - directed scenarios plus random stimulus against a queue-based model
module tb_snake_game_ctrl;

   localparam int NP = 2;
   localparam int QD = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NP-1:0] up, down, left, right, col;
   logic          enter, pause, tick;
   logic [2*NP-1:0] dir;
   logic          run_en;
   logic [1:0]    game_state;
   logic [NP-1:0] loser, q_full;

   int total = 0;
   int bad   = 0;

   int         m_state;
   logic [1:0] m_dir [NP];
   logic [1:0] m_q [NP][$];
   logic [NP-1:0] m_loser;
   int         opp [4] = '{1, 0, 3, 2};

   snake_game_ctrl #(.NUM_PLAYERS(NP), .QDEPTH(QD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .up_pulse    (up),
      .down_pulse  (down),
      .left_pulse  (left),
      .right_pulse (right),
      .enter_pulse (enter),
      .pause_pulse (pause),
      .tick        (tick),
      .collision   (col),
      .dir         (dir),
      .run_en      (run_en),
      .game_state  (game_state),
      .loser       (loser),
      .q_full      (q_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      up = '0; down = '0; left = '0; right = '0; col = '0;
      enter = 1'b0; pause = 1'b0; tick = 1'b0;
   endtask

   task automatic model_reset();
      m_state = 0;
      m_loser = '0;
      for (int p = 0; p < NP; p++) begin
         m_dir[p] = 2'd0;
         m_q[p].delete();
      end
   endtask

   task automatic model_step();
      logic [1:0] c, r;
      bit v, rej, acc, pop_ok;
      acc    = (m_state == 1) || (m_state == 2);
      pop_ok = (m_state == 1) && tick;
      for (int p = 0; p < NP; p++) begin
         v = up[p] | down[p] | left[p] | right[p];
         c = up[p] ? 2'd2 : down[p] ? 2'd3 : left[p] ? 2'd1 : 2'd0;
         r = (m_q[p].size() != 0) ? m_q[p][$] : m_dir[p];
         rej = (c == r);
`ifdef GCTRL_REVERSE_REJECT_EN
         if (int'(c) == opp[r]) rej = 1'b1;
`endif
         if (pop_ok && m_q[p].size() != 0) m_dir[p] = m_q[p].pop_front();
         if (acc && v && !rej) begin
            if (m_q[p].size() == QD) m_q[p][m_q[p].size()-1] = c;
            else                     m_q[p].push_back(c);
         end
      end
      case (m_state)
         0: if (enter) m_state = 1;
         1: begin
            if (|col) begin
               m_loser = col;
               m_state = 3;
            end else if (pause) m_state = 2;
         end
         2: if (pause || enter) m_state = 1;
         default: if (enter) begin
            m_state = 0;
            m_loser = '0;
            for (int p = 0; p < NP; p++) begin
               m_dir[p] = 2'd0;
               m_q[p].delete();
            end
         end
      endcase
   endtask

   task automatic check_all();
      chk("state", game_state, m_state);
      chk("run_en", run_en, (m_state == 1));
      chk("loser", loser, m_loser);
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("dir%0d", p), dir[2*p +: 2], m_dir[p]);
         chk($sformatf("q_full%0d", p), q_full[p], (m_q[p].size() == QD));
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
      clear_inputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("rst_state", game_state, 0);
      chk("rst_dir", dir, 0);
      chk("rst_qfull", q_full, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #2;
      do_reset();

      enter = 1'b1; cyc();
      chk("t1_state", game_state, 1);
      chk("t1_run_en", run_en, 1);
      chk("t1_dir", dir[1:0], 0);
      tick = 1'b1; cyc();
      chk("t1_tick_dir", dir[1:0], 0);

      up[0] = 1'b1; cyc();
      chk("t2_full_a", q_full[0], 0);
      left[0] = 1'b1; cyc();
      chk("t2_full_b", q_full[0], 1);
      tick = 1'b1; cyc();
      chk("t2_dir_a", dir[1:0], 2);
      chk("t2_full_c", q_full[0], 0);
      tick = 1'b1; cyc();
      chk("t2_dir_b", dir[1:0], 1);

      do_reset();
      enter = 1'b1; cyc();
      left[0] = 1'b1; cyc();
      tick = 1'b1; cyc();
`ifdef GCTRL_REVERSE_REJECT_EN
      chk("t3_dir", dir[1:0], 0);
`else
      chk("t3_dir", dir[1:0], 1);
`endif

      do_reset();
      enter = 1'b1; cyc();
      up[0] = 1'b1; cyc();
      left[0] = 1'b1; cyc();
      down[0] = 1'b1; cyc();
      tick = 1'b1; cyc();
      chk("t4_dir_a", dir[1:0], 2);
      tick = 1'b1; cyc();
      chk("t4_dir_b", dir[1:0], 3);

      col[0] = 1'b1; pause = 1'b1; cyc();
      chk("t5_state", game_state, 3);
      chk("t5_loser", loser[0], 1);
      enter = 1'b1; cyc();
      chk("t5_idle", game_state, 0);
      chk("t5_dir", dir, 0);
      chk("t5_loser_clr", loser, 0);

      enter = 1'b1; cyc();
      pause = 1'b1; cyc();
      chk("t6_pause", game_state, 2);
      up[0] = 1'b1; cyc();
      tick = 1'b1; cyc();
      chk("t6_dir_held", dir[1:0], 0);
      pause = 1'b1; cyc();
      chk("t6_resume", game_state, 1);
      tick = 1'b1; cyc();
      chk("t6_dir", dir[1:0], 2);
      left[0] = 1'b1; right[1] = 1'b1; cyc();
      do_reset();
      chk("t6_rst_run_en", run_en, 0);
      chk("t6_rst_loser", loser, 0);

      enter = 1'b1; cyc();
      for (int n = 0; n < 4000; n++) begin
         for (int p = 0; p < NP; p++) begin
            up[p]    = ($urandom % 5) == 0;
            down[p]  = ($urandom % 5) == 0;
            left[p]  = ($urandom % 5) == 0;
            right[p] = ($urandom % 5) == 0;
            col[p]   = ($urandom % 60) == 0;
         end
         enter = ($urandom % 20) == 0;
         pause = ($urandom % 25) == 0;
         tick  = ($urandom % 3) == 0;
         if (($urandom % 500) == 0) begin
            clear_inputs();
            do_reset();
         end else begin
            cyc();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
